// File: rtl/letc_core_pkg.sv
// Shared types for the Memory 2 atomic engine and its ALU.
package letc_core_pkg;

  // Request class as presented by the M1/M2 pipeline register
  typedef enum logic [1:0] {
    AMO_KIND_AMO = 2'd0,
    AMO_KIND_LR  = 2'd1,
    AMO_KIND_SC  = 2'd2
  } amo_kind_e;

  // Read-modify-write operation selector (encoding shared with the decoder)
  typedef enum logic [3:0] {
    AMO_OP_SWAP = 4'd0,
    AMO_OP_ADD  = 4'd1,
    AMO_OP_AND  = 4'd2,
    AMO_OP_OR   = 4'd3,
    AMO_OP_XOR  = 4'd4,
    AMO_OP_MIN  = 4'd5,
    AMO_OP_MAX  = 4'd6,
    AMO_OP_MINU = 4'd7,
    AMO_OP_MAXU = 4'd8
  } amo_alu_op_e;

  // Sequencer state, kept as plain constants so older tools can read it
  typedef logic [2:0] amo_state_e;
  localparam amo_state_e ST_IDLE    = 3'd0;
  localparam amo_state_e ST_RD_REQ  = 3'd1;
  localparam amo_state_e ST_RD_WAIT = 3'd2;
  localparam amo_state_e ST_WR_REQ  = 3'd3;
  localparam amo_state_e ST_WR_WAIT = 3'd4;
  localparam amo_state_e ST_RSP     = 3'd5;

endpackage

// File: rtl/letc_core_amo_alu.sv
// Combinational AMO arithmetic: new = op(old, rs2). Unknown ops keep old.
module letc_core_amo_alu
  import letc_core_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  amo_alu_op_e       i_op,
  input  logic [DATA_W-1:0] i_old,
  input  logic [DATA_W-1:0] i_rs2,
  output logic [DATA_W-1:0] o_new
);

  logic w_lt_s;
  logic w_lt_u;

  assign w_lt_s = $signed(i_old) < $signed(i_rs2);
  assign w_lt_u = i_old < i_rs2;

  // Select the operation result; anything unrecognised writes old back
  always_comb begin
    o_new = i_old;
    case (i_op)
      AMO_OP_SWAP: o_new = i_rs2;
      AMO_OP_ADD:  o_new = i_old + i_rs2;
      AMO_OP_AND:  o_new = i_old & i_rs2;
      AMO_OP_OR:   o_new = i_old | i_rs2;
      AMO_OP_XOR:  o_new = i_old ^ i_rs2;
      AMO_OP_MIN:  o_new = w_lt_s ? i_old : i_rs2;
      AMO_OP_MAX:  o_new = w_lt_s ? i_rs2 : i_old;
      AMO_OP_MINU: o_new = w_lt_u ? i_old : i_rs2;
      AMO_OP_MAXU: o_new = w_lt_u ? i_rs2 : i_old;
      default:     o_new = i_old;
    endcase
  end

endmodule

// File: rtl/letc_core_m2_amo_engine.sv
// Memory 2 atomic engine: sequences AMO / LR / SC against a variable-latency
// data port, holds M2 not-ready while busy, and owns the LR/SC reservation.
module letc_core_m2_amo_engine
  import letc_core_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 32,
  parameter int RSV_GRAN_LOG2 = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [1:0]        i_req_kind,
  input  logic [3:0]        i_req_op,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_rs2,
  input  logic              i_flush,
  output logic              o_mem_req_valid,
  input  logic              i_mem_req_ready,
  output logic              o_mem_req_we,
  output logic [ADDR_W-1:0] o_mem_req_addr,
  output logic [DATA_W-1:0] o_mem_req_wdata,
  input  logic              i_mem_rsp_valid,
  input  logic [DATA_W-1:0] i_mem_rsp_rdata,
  input  logic              i_mem_rsp_err,
  input  logic              i_snoop_inval,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err
);

  localparam int RSV_W = ADDR_W - RSV_GRAN_LOG2;

  amo_state_e        r_state;
  amo_kind_e         r_kind;
  amo_alu_op_e       r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_rs2;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_result;
  logic              r_err;
  logic              r_kill;
  logic              r_rsv_valid;
  logic [RSV_W-1:0]  r_rsv_addr;

  amo_kind_e         w_req_kind;
  logic              w_accept;
  logic              w_rsv_hit;
  logic              w_rd_done;
  logic              w_rd_kill;
  logic              w_lr_set;
  logic              w_sc_clr;
  logic [DATA_W-1:0] w_alu_new;

  assign w_req_kind = amo_kind_e'(i_req_kind);
  assign w_accept   = (r_state == ST_IDLE) && i_req_valid && !i_flush;
  // A snoop landing in the same cycle as the SC already invalidates it
  assign w_rsv_hit  = r_rsv_valid && !i_snoop_inval &&
                      (r_rsv_addr == i_req_addr[ADDR_W-1:RSV_GRAN_LOG2]);
  assign w_rd_done  = (r_state == ST_RD_WAIT) && i_mem_rsp_valid;
  assign w_rd_kill  = r_kill || i_flush;
  assign w_lr_set   = w_rd_done && (r_kind == AMO_KIND_LR) && !i_mem_rsp_err && !w_rd_kill;
  // Every SC consumes the reservation, whether it succeeds or not
  assign w_sc_clr   = w_accept && (w_req_kind == AMO_KIND_SC);

  // The new value is computed straight off the read response and registered
  letc_core_amo_alu #(.DATA_W(DATA_W)) u_alu (
    .i_op  (r_op),
    .i_old (i_mem_rsp_rdata),
    .i_rs2 (r_rs2),
    .o_new (w_alu_new)
  );

  assign o_req_ready     = (r_state == ST_IDLE);
  assign o_mem_req_valid = (r_state == ST_RD_REQ) || (r_state == ST_WR_REQ);
  assign o_mem_req_we    = (r_state == ST_WR_REQ);
  assign o_mem_req_addr  = r_addr;
  assign o_mem_req_wdata = r_wdata;
  assign o_rsp_valid     = (r_state == ST_RSP) && !r_kill;
  assign o_rsp_rdata     = r_result;
  assign o_rsp_err       = r_err;

  // Sequencer: one memory transaction outstanding at most, result pulse at the end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_kind   <= AMO_KIND_AMO;
      r_op     <= AMO_OP_SWAP;
      r_addr   <= '0;
      r_rs2    <= '0;
      r_wdata  <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
      r_kill   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_kind   <= w_req_kind;
            r_op     <= amo_alu_op_e'(i_req_op);
            r_addr   <= i_req_addr;
            r_rs2    <= i_req_rs2;
            r_wdata  <= i_req_rs2;
            r_result <= '0;
            r_err    <= 1'b0;
            if (w_req_kind == AMO_KIND_SC) begin
              if (w_rsv_hit) begin
                r_state <= ST_WR_REQ;
              end else begin
                r_result <= DATA_W'(1);
                r_state  <= ST_RSP;
              end
            end else begin
              r_state <= ST_RD_REQ;
            end
          end
        end
        ST_RD_REQ: begin
          // Once the read is handed over it must drain, so a coincident flush becomes a kill
          if (i_mem_req_ready) begin
            r_kill  <= i_flush;
            r_state <= ST_RD_WAIT;
          end else if (i_flush) begin
            r_state <= ST_IDLE;
          end
        end
        ST_RD_WAIT: begin
          if (i_flush) r_kill <= 1'b1;
          if (i_mem_rsp_valid) begin
            r_result <= i_mem_rsp_rdata;
            r_err    <= i_mem_rsp_err;
            if (i_mem_rsp_err || w_rd_kill || (r_kind == AMO_KIND_LR)) begin
              r_state <= ST_RSP;
            end else begin
              r_wdata <= w_alu_new;
              r_state <= ST_WR_REQ;
            end
          end
        end
        ST_WR_REQ: begin
          // The write still goes out on flush so the AMO stays atomic
          if (i_flush) r_kill <= 1'b1;
          if (i_mem_req_ready) r_state <= ST_WR_WAIT;
        end
        ST_WR_WAIT: begin
          if (i_flush) r_kill <= 1'b1;
          if (i_mem_rsp_valid) begin
            r_err <= i_mem_rsp_err;
            if (r_kind == AMO_KIND_SC) r_result <= DATA_W'(i_mem_rsp_err);
            r_state <= ST_RSP;
          end
        end
        ST_RSP: begin
          r_kill  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_kill  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Single reservation: snoop or SC clears (clear wins), a completed LR sets
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsv_valid <= 1'b0;
      r_rsv_addr  <= '0;
    end else if (i_snoop_inval || w_sc_clr) begin
      r_rsv_valid <= 1'b0;
    end else if (w_lr_set) begin
      r_rsv_valid <= 1'b1;
      r_rsv_addr  <= r_addr[ADDR_W-1:RSV_GRAN_LOG2];
    end
  end

endmodule
